// File: rtl/cv32e40p_instr_obi_arbiter.sv
// cv32e40p_instr_obi_arbiter: shares the instruction OBI port between two fetch requesters,
// holding ungranted requests stable and routing responses in order via an owner-ID FIFO.
`default_nettype none

module cv32e40p_instr_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ARB_MODE        = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_trans_valid_i,
  output logic        r0_trans_ready_o,
  input  logic [31:0] r0_trans_addr_i,
  output logic        r0_resp_valid_o,
  output logic [31:0] r0_resp_rdata_o,
  output logic        r0_resp_err_o,
  input  logic        r1_trans_valid_i,
  output logic        r1_trans_ready_o,
  input  logic [31:0] r1_trans_addr_i,
  output logic        r1_resp_valid_o,
  output logic [31:0] r1_resp_rdata_o,
  output logic        r1_resp_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    TRANSPARENT = 1'b0,
    HOLD        = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                addr_q, addr_d;
  logic                       owner_q, owner_d;
  logic                       rr_last_q, rr_last_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              wr_idx;

  logic        room, sel, sel_valid, push, push_id, pop, head;
  logic [31:0] sel_addr;

  // Room uses the registered count so rvalid never reaches instr_req_o combinationally.
  assign room      = (cnt_q < CW'(MAX_OUTSTANDING));
  assign sel_valid = r0_trans_valid_i || r1_trans_valid_i;
  assign sel_addr  = sel ? r1_trans_addr_i : r0_trans_addr_i;
  assign head      = fifo_q[0];
  assign pop       = instr_rvalid_i && (cnt_q != '0);

  always_comb begin
    if (r0_trans_valid_i && r1_trans_valid_i) begin
      sel = (ARB_MODE == 1) ? 1'b0 : ~rr_last_q;
    end else begin
      sel = r1_trans_valid_i && !r0_trans_valid_i;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    owner_d          = owner_q;
    rr_last_d        = rr_last_q;
    instr_req_o      = 1'b0;
    instr_addr_o     = {sel_addr[31:2], 2'b00};
    r0_trans_ready_o = 1'b0;
    r1_trans_ready_o = 1'b0;
    push             = 1'b0;
    push_id          = sel;
    case (state_q)
      TRANSPARENT: begin
        instr_req_o      = sel_valid && room;
        r0_trans_ready_o = room && !sel;
        r1_trans_ready_o = room && sel;
        if (sel_valid && room) begin
          rr_last_d = sel;
          if (instr_gnt_i) begin
            push = 1'b1;
          end else begin
            state_d = HOLD;
            addr_d  = {sel_addr[31:2], 2'b00};
            owner_d = sel;
          end
        end
      end
      HOLD: begin
        instr_req_o  = 1'b1;
        instr_addr_o = addr_q;
        push_id      = owner_q;
        if (instr_gnt_i) begin
          push    = 1'b1;
          state_d = TRANSPARENT;
        end
      end
      default: state_d = TRANSPARENT;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q;
    if (pop) begin
      fifo_d = fifo_q >> 1;
      cnt_d  = cnt_q - 1'b1;
      wr_idx = cnt_q - 1'b1;
    end
    if (push) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (CW'(i) == wr_idx) fifo_d[i] = push_id;
      end
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TRANSPARENT;
      addr_q    <= '0;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      fifo_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      fifo_q    <= fifo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign r0_resp_valid_o = pop && !head;
  assign r1_resp_valid_o = pop && head;
  assign r0_resp_rdata_o = r0_resp_valid_o ? instr_rdata_i : '0;
  assign r1_resp_rdata_o = r1_resp_valid_o ? instr_rdata_i : '0;
  assign r0_resp_err_o   = r0_resp_valid_o && instr_err_i;
  assign r1_resp_err_o   = r1_resp_valid_o && instr_err_i;
  assign busy_o          = (cnt_q != '0) || (state_q == HOLD);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(instr_rvalid_i && (cnt_q == '0)))
        else $error("instr_rvalid_i with no outstanding transaction");
    end
  end
`endif

endmodule

`default_nettype wire
